// File: rtl/router_pkg.sv
// Shared types for the router ingress path: beat record, read-FSM states,
// and the saturating counter helper.
package router_pkg;

    localparam int DEST_W = 8;
    localparam int DATA_W = 64;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              hdr;
        logic              pld;
        logic              sof;
        logic              eof;
    } beat_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FWD,
        ST_DROP
    } state_t;

    // Adds 0..2 events and sticks at all-ones.
    function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, cnt} + {15'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/router_demux4_if.sv
// Ingress beat stream plus egress stream toward the output muxes for one source.
interface router_demux4_if #(
    parameter int NumPorts = 4
);
    import router_pkg::*;

    logic [DATA_W-1:0]   D;
    logic                D_HDR_VALID;
    logic                D_PLD_VALID;
    logic                D_SOF;
    logic                D_EOF;
    logic                D_BP;
    logic [DATA_W-1:0]   Q;
    logic [DEST_W-1:0]   Q_DEST;
    logic                Q_DEST_VALID;
    logic                Q_HDR_VALID;
    logic                Q_PLD_VALID;
    logic                Q_SOF;
    logic                Q_EOF;
    logic [NumPorts-1:0] Q_BP;
    logic [NumPorts-1:0] COLLISION;

    // Environment side: link receiver and output muxes.
    modport master (
        output D, D_HDR_VALID, D_PLD_VALID, D_SOF, D_EOF, Q_BP, COLLISION,
        input  D_BP, Q, Q_DEST, Q_DEST_VALID, Q_HDR_VALID, Q_PLD_VALID, Q_SOF, Q_EOF
    );

    modport slave (
        input  D, D_HDR_VALID, D_PLD_VALID, D_SOF, D_EOF, Q_BP, COLLISION,
        output D_BP, Q, Q_DEST, Q_DEST_VALID, Q_HDR_VALID, Q_PLD_VALID, Q_SOF, Q_EOF
    );

endinterface

// File: rtl/router_beat_fifo.sv
// Synchronous beat FIFO with occupancy; a pop in the same cycle frees room for a push when full.
module router_beat_fifo
    import router_pkg::*;
#(
    parameter int Depth = 4,
    localparam int AW = $clog2(Depth)
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        push,
    input  beat_t       push_beat,
    input  logic        pop,
    output beat_t       head,
    output logic        empty,
    output logic        full,
    output logic [AW:0] count
);

    beat_t         mem [Depth];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(Depth));
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign head  = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_ptr] <= push_beat;
    end

endmodule

// File: rtl/router_demux4.sv
// Ingress frame distributor: buffers link beats, routes or discards whole frames,
// and presents them with a stable destination tag to every output mux.
module router_demux4
    import router_pkg::*;
#(
    parameter int NumPorts  = 4,
    parameter int DestLsb   = 56,
    parameter int FifoDepth = 4
) (
    input  logic          CLK,
    input  logic          RST,
    router_demux4_if.slave bus,
    output logic [15:0]   DROP_CNT,
    output logic [15:0]   COLL_CNT,
    output logic [15:0]   ERR_CNT
);

    localparam int AW = $clog2(FifoDepth);
    localparam int PW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    beat_t             in_beat;
    beat_t             head;
    logic              push, pop, empty, full, wr_ok;
    logic [AW:0]       count, count_n;
    state_t            state, state_n;
    logic              emit, latch_dest, drop_ev, disc_err, ovf_ev;
    logic [DEST_W-1:0] head_dest;
    logic [PW-1:0]     dest_idx;
    logic              coll_hit, coll_ev, coll_flag, coll_flag_n, sof_q, single_q;

    assign push    = bus.D_HDR_VALID | bus.D_PLD_VALID;
    assign in_beat = '{data: bus.D, hdr: bus.D_HDR_VALID, pld: bus.D_PLD_VALID,
                       sof: bus.D_SOF, eof: bus.D_EOF};

    router_beat_fifo #(.Depth(FifoDepth)) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (push),
        .push_beat (in_beat),
        .pop       (pop),
        .head      (head),
        .empty     (empty),
        .full      (full),
        .count     (count)
    );

    assign wr_ok     = push && (!full || pop);
    assign ovf_ev    = push && full && !pop;
    assign count_n   = count + (AW+1)'(wr_ok) - (AW+1)'(pop);
    assign head_dest = head.data[DestLsb +: DEST_W];
    assign dest_idx  = bus.Q_DEST[PW-1:0];

    always_comb begin
        state_n    = state;
        pop        = 1'b0;
        emit       = 1'b0;
        latch_dest = 1'b0;
        drop_ev    = 1'b0;
        disc_err   = 1'b0;
        case (state)
            ST_IDLE: if (!empty) begin
                pop = 1'b1;
                if (!head.sof) begin
                    disc_err = 1'b1;
                end else if (32'(head_dest) < NumPorts) begin
                    emit       = 1'b1;
                    latch_dest = 1'b1;
                    if (!head.eof) state_n = ST_FWD;
                end else begin
                    drop_ev = 1'b1;
                    if (!head.eof) state_n = ST_DROP;
                end
            end
            ST_FWD: if (!empty && !bus.Q_BP[dest_idx]) begin
                pop = 1'b1;
                // A nested SOF is junk; the open frame keeps going.
                if (head.sof) begin
                    disc_err = 1'b1;
                end else begin
                    emit = 1'b1;
                    if (head.eof) state_n = ST_IDLE;
                end
            end
            ST_DROP: if (!empty) begin
                pop = 1'b1;
                if (head.eof) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // single_q covers a one-beat frame whose collision report lands after its EOF.
    assign coll_hit    = bus.COLLISION[dest_idx] && (state == ST_FWD || sof_q);
    assign coll_ev     = (emit && state == ST_FWD && head.eof && (coll_flag || coll_hit))
                       || (single_q && coll_hit);
    assign coll_flag_n = (state == ST_FWD) && (state_n == ST_FWD) && (coll_flag || coll_hit);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state            <= ST_IDLE;
            bus.D_BP         <= 1'b0;
            bus.Q            <= '0;
            bus.Q_DEST       <= '0;
            bus.Q_DEST_VALID <= 1'b0;
            bus.Q_HDR_VALID  <= 1'b0;
            bus.Q_PLD_VALID  <= 1'b0;
            bus.Q_SOF        <= 1'b0;
            bus.Q_EOF        <= 1'b0;
            coll_flag        <= 1'b0;
            sof_q            <= 1'b0;
            single_q         <= 1'b0;
            DROP_CNT         <= '0;
            COLL_CNT         <= '0;
            ERR_CNT          <= '0;
        end else begin
            state           <= state_n;
            // Two slots of headroom cover the upstream's one-cycle reaction.
            bus.D_BP        <= 32'(count_n) >= FifoDepth - 2;
            bus.Q_HDR_VALID <= emit && head.hdr;
            bus.Q_PLD_VALID <= emit && head.pld;
            bus.Q_SOF       <= emit && head.sof;
            bus.Q_EOF       <= emit && head.eof;
            if (emit)       bus.Q      <= head.data;
            if (latch_dest) bus.Q_DEST <= head_dest;
            if (latch_dest)     bus.Q_DEST_VALID <= 1'b1;
            else if (bus.Q_EOF) bus.Q_DEST_VALID <= 1'b0;
            coll_flag <= coll_flag_n;
            sof_q     <= emit && head.sof;
            single_q  <= emit && head.sof && head.eof;
            DROP_CNT  <= sat_add(DROP_CNT, {1'b0, drop_ev});
            COLL_CNT  <= sat_add(COLL_CNT, {1'b0, coll_ev});
            ERR_CNT   <= sat_add(ERR_CNT, 2'(ovf_ev) + 2'(disc_err));
        end
    end

endmodule

// File: tb/tb_router_demux4.sv
// Directed bench for router_demux4: hand-computed frames, latencies and counter values.
module tb_router_demux4;
    import router_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] drop_cnt, coll_cnt, err_cnt;
    int          n_chk = 0;
    int          n_err = 0;
    int          sent;
    bit          saw_bp;
    logic [63:0] t2_beats [8];
    logic [63:0] exp_d [$];
    logic [63:0] mon_d [$];
    logic [1:0]  mon_f [$];

    router_demux4_if #(.NumPorts(4)) bus ();

    router_demux4 #(.NumPorts(4), .DestLsb(56), .FifoDepth(4)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .bus      (bus.slave),
        .DROP_CNT (drop_cnt),
        .COLL_CNT (coll_cnt),
        .ERR_CNT  (err_cnt)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (!RST && (bus.Q_HDR_VALID || bus.Q_PLD_VALID)) begin
            mon_d.push_back(bus.Q);
            mon_f.push_back({bus.Q_SOF, bus.Q_EOF});
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic beat(input logic [63:0] d, input logic hdr, input logic pld,
                        input logic sof, input logic eof);
        bus.D = d; bus.D_HDR_VALID = hdr; bus.D_PLD_VALID = pld;
        bus.D_SOF = sof; bus.D_EOF = eof;
    endtask

    task automatic idle_in();
        beat(64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send(input logic [63:0] d, input logic hdr, input logic sof, input logic eof);
        beat(d, hdr, !hdr, sof, eof);
        step();
    endtask

    task automatic chk_stream(input string tag);
        chk({tag, "_len"}, 64'(mon_d.size()), 64'(exp_d.size()));
        for (int i = 0; i < exp_d.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i),
                (i < mon_d.size()) ? mon_d[i] : 64'hBAD0_BAD0_BAD0_BAD0, exp_d[i]);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_q"}, bus.Q, 64'd0);
        chk({tag, "_dest"}, 64'(bus.Q_DEST), 64'd0);
        chk({tag, "_dv"}, 64'(bus.Q_DEST_VALID), 64'd0);
        chk({tag, "_vld"}, 64'({bus.Q_HDR_VALID, bus.Q_PLD_VALID, bus.Q_SOF, bus.Q_EOF}), 64'd0);
        chk({tag, "_dbp"}, 64'(bus.D_BP), 64'd0);
        chk({tag, "_cnts"}, {16'd0, drop_cnt, coll_cnt, err_cnt}, 64'd0);
    endtask

    task automatic clear_mon();
        mon_d.delete();
        mon_f.delete();
        exp_d.delete();
    endtask

    initial begin
        idle_in();
        bus.Q_BP = '0;
        bus.COLLISION = '0;

        // Reset state
        step(); step();
        chk_all_zero("rst");
        RST = 1'b0;

        // 3-beat frame to DEST=2, two-cycle latency
        beat(64'h0200_0000_0000_00A1, 1'b1, 1'b0, 1'b1, 1'b0); step();
        beat(64'h0000_0000_0000_00A2, 1'b0, 1'b1, 1'b0, 1'b0); step();
        chk("t1_sof", 64'(bus.Q_SOF), 64'd1);
        chk("t1_hdrv", 64'(bus.Q_HDR_VALID), 64'd1);
        chk("t1_q0", bus.Q, 64'h0200_0000_0000_00A1);
        chk("t1_dest", 64'(bus.Q_DEST), 64'd2);
        chk("t1_dv0", 64'(bus.Q_DEST_VALID), 64'd1);
        beat(64'h0000_0000_0000_00A3, 1'b0, 1'b1, 1'b0, 1'b1); step();
        chk("t1_q1", bus.Q, 64'h0000_0000_0000_00A2);
        chk("t1_pldv", 64'(bus.Q_PLD_VALID), 64'd1);
        chk("t1_dv1", 64'(bus.Q_DEST_VALID), 64'd1);
        idle_in(); step();
        chk("t1_q2", bus.Q, 64'h0000_0000_0000_00A3);
        chk("t1_eof", 64'(bus.Q_EOF), 64'd1);
        chk("t1_dv2", 64'(bus.Q_DEST_VALID), 64'd1);
        step();
        chk("t1_vld_off", 64'({bus.Q_HDR_VALID, bus.Q_PLD_VALID, bus.Q_SOF, bus.Q_EOF}), 64'd0);
        chk("t1_dv_off", 64'(bus.Q_DEST_VALID), 64'd0);
        chk("t1_q_hold", bus.Q, 64'h0000_0000_0000_00A3);
        chk("t1_cnts", {16'd0, drop_cnt, coll_cnt, err_cnt}, 64'd0);

        // Q_BP[2] held 5 cycles mid-frame; upstream honours D_BP
        clear_mon();
        t2_beats[0] = 64'h0200_0000_0000_0020;
        for (int i = 1; i < 8; i++) t2_beats[i] = 64'h2000 + 64'(i);
        for (int i = 0; i < 8; i++) exp_d.push_back(t2_beats[i]);
        sent = 0;
        saw_bp = 1'b0;
        for (int c = 0; c < 60; c++) begin
            bus.Q_BP = (c >= 4 && c < 9) ? 4'b0100 : 4'b0000;
            if (bus.D_BP) saw_bp = 1'b1;
            if (sent < 8 && !bus.D_BP) begin
                beat(t2_beats[sent], sent == 0, sent != 0, sent == 0, sent == 7);
                sent++;
            end else begin
                idle_in();
            end
            step();
        end
        bus.Q_BP = '0;
        chk("t2_sent", 64'(sent), 64'd8);
        chk("t2_dbp_seen", 64'(saw_bp), 64'd1);
        chk("t2_err", 64'(err_cnt), 64'd0);
        chk_stream("t2");
        chk("t2_last_eof", 64'((mon_f.size() == 8) ? mon_f[7] : 2'b11), 64'd1);

        // DEST=9 frame dropped, next frame to DEST=0 forwarded
        clear_mon();
        send(64'h0900_0000_0000_0090, 1'b1, 1'b1, 1'b0);
        send(64'h0000_0000_0000_0091, 1'b0, 1'b0, 1'b0);
        send(64'h0000_0000_0000_0092, 1'b0, 1'b0, 1'b1);
        send(64'h0000_0000_0000_0030, 1'b1, 1'b1, 1'b0);
        send(64'h0000_0000_0000_0031, 1'b0, 1'b0, 1'b1);
        idle_in();
        repeat (6) step();
        exp_d.push_back(64'h0000_0000_0000_0030);
        exp_d.push_back(64'h0000_0000_0000_0031);
        chk_stream("t3");
        chk("t3_drop", 64'(drop_cnt), 64'd1);
        chk("t3_err", 64'(err_cnt), 64'd0);

        // Orphan payload, then a nested SOF inside a DEST=3 frame
        clear_mon();
        send(64'h0000_0000_0000_0040, 1'b0, 1'b0, 1'b0);
        send(64'h0300_0000_0000_0041, 1'b1, 1'b1, 1'b0);
        send(64'h0000_0000_0000_0042, 1'b0, 1'b0, 1'b0);
        send(64'h0100_0000_0000_0043, 1'b1, 1'b1, 1'b0);
        send(64'h0000_0000_0000_0044, 1'b0, 1'b0, 1'b1);
        idle_in();
        repeat (6) step();
        exp_d.push_back(64'h0300_0000_0000_0041);
        exp_d.push_back(64'h0000_0000_0000_0042);
        exp_d.push_back(64'h0000_0000_0000_0044);
        chk_stream("t4");
        chk("t4_err", 64'(err_cnt), 64'd2);
        chk("t4_dest", 64'(bus.Q_DEST), 64'd3);

        // COLLISION[1] pulse during a DEST=1 frame
        clear_mon();
        send(64'h0100_0000_0000_0050, 1'b1, 1'b1, 1'b0);
        beat(64'h0000_0000_0000_0051, 1'b0, 1'b1, 1'b0, 1'b0); step();
        bus.COLLISION = 4'b0010;
        beat(64'h0000_0000_0000_0052, 1'b0, 1'b1, 1'b0, 1'b0); step();
        bus.COLLISION = 4'b0000;
        chk("t5_coll_mid", 64'(coll_cnt), 64'd0);
        beat(64'h0000_0000_0000_0053, 1'b0, 1'b1, 1'b0, 1'b1); step();
        idle_in();
        repeat (5) step();
        for (int i = 0; i < 4; i++) exp_d.push_back(64'h0100_0000_0000_0050 * 64'(i == 0) + 64'h50 * 64'(i != 0) + 64'(i));
        chk_stream("t5");
        chk("t5_coll", 64'(coll_cnt), 64'd1);
        chk("t5_drop", 64'(drop_cnt), 64'd1);

        // Reset mid-frame, then a fresh frame
        beat(64'h0200_0000_0000_0060, 1'b1, 1'b0, 1'b1, 1'b0); step();
        beat(64'h0000_0000_0000_0061, 1'b0, 1'b1, 1'b0, 1'b0); step();
        chk("t6_sof", 64'(bus.Q_SOF), 64'd1);
        idle_in();
        RST = 1'b1;
        step();
        chk_all_zero("t6_rst");
        RST = 1'b0;
        beat(64'h0300_0000_0000_0070, 1'b1, 1'b0, 1'b1, 1'b0); step();
        beat(64'h0000_0000_0000_0071, 1'b0, 1'b1, 1'b0, 1'b1); step();
        chk("t6_sof2", 64'(bus.Q_SOF), 64'd1);
        chk("t6_q0", bus.Q, 64'h0300_0000_0000_0070);
        chk("t6_dest", 64'(bus.Q_DEST), 64'd3);
        idle_in(); step();
        chk("t6_q1", bus.Q, 64'h0000_0000_0000_0071);
        chk("t6_eof", 64'(bus.Q_EOF), 64'd1);
        step();
        chk("t6_vld_off", 64'({bus.Q_HDR_VALID, bus.Q_PLD_VALID, bus.Q_SOF, bus.Q_EOF}), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
